onchip_mem_arbiter: RTL and testbench



---
 rtl/onchip_mem_pkg.sv | 13 +
 rtl/onchip_mem_arbiter_if.sv | 30 +++
 rtl/onchip_mem_arbiter_rr_arb2.sv | 28 ++
 rtl/onchip_mem_arbiter.sv | 103 ++++++++++
 tb/tb_onchip_mem_arbiter.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/onchip_mem_pkg.sv
// Shared constants for the two-master on-chip RAM arbiter.
package onchip_mem_pkg;

  localparam int DEF_ADDR_W = 10;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_BE_W   = DEF_DATA_W / 8;

  typedef logic master_id_t;

  localparam master_id_t M0 = 1'b0;
  localparam master_id_t M1 = 1'b1;

endpackage

// File: rtl/onchip_mem_arbiter_if.sv
// One Avalon-MM port into the arbiter; instantiate once per bus master.
interface onchip_mem_arbiter_if
  import onchip_mem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int BE_W   = DEF_BE_W
) ();

  logic [ADDR_W-1:0] address;
  logic [BE_W-1:0]   byteenable;
  logic              read;
  logic              write;
  logic [DATA_W-1:0] writedata;
  logic              lock;
  logic              waitrequest;
  logic [DATA_W-1:0] readdata;
  logic              readdatavalid;

  modport master (
    output address, byteenable, read, write, writedata, lock,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, byteenable, read, write, writedata, lock,
    output waitrequest, readdata, readdatavalid
  );

endinterface

// File: rtl/onchip_mem_arbiter_rr_arb2.sv
// Combinational two-way round-robin grant with lock override.
// lock_break forces the grant away from the lock owner for one arbitration.
module rr_arb2
  import onchip_mem_pkg::*;
(
  input  logic [1:0] req,
  input  master_id_t last_grant,
  input  logic       lock_valid,
  input  master_id_t lock_owner,
  input  logic       lock_break,
  output logic       gnt_valid,
  output master_id_t gnt_id
);

  always_comb begin
    gnt_valid = |req;
    gnt_id    = M0;
    if (lock_break)
      gnt_id = ~lock_owner;
    else if (lock_valid && req[lock_owner])
      gnt_id = lock_owner;
    else if (req == 2'b11)
      gnt_id = ~last_grant;
    else if (req[1])
      gnt_id = M1;
  end

endmodule

// File: rtl/onchip_mem_arbiter.sv
// Shares the single-port 1024x32 on-chip RAM between two Avalon-MM masters:
// round-robin with optional per-master lock, bounded by LOCK_MAX consecutive locked grants.
module onchip_mem_arbiter
  import onchip_mem_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int BE_W     = DEF_BE_W,
  parameter int LOCK_MAX = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  onchip_mem_arbiter_if.slave m0,
  onchip_mem_arbiter_if.slave m1,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [BE_W-1:0]     mem_byteenable,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic [DATA_W-1:0]   mem_writedata,
  output logic                mem_clken,
  input  logic [DATA_W-1:0]   mem_readdata
);

  localparam int CNT_W = $clog2(LOCK_MAX + 1);

  logic [1:0]       rd, wr, lk, req;
  logic             gnt_valid, lock_break, locked_grant;
  master_id_t       gnt_id;
  master_id_t       last_grant, lock_owner, rsp_id;
  logic             lock_valid, rsp_valid;
  logic [CNT_W-1:0] lock_cnt;

  // Requests are masked in reset so every output falls to its idle value.
  assign rd  = {m1.read,  m0.read}  & {2{reset_n}};
  assign wr  = {m1.write, m0.write} & {2{reset_n}};
  assign lk  = {m1.lock,  m0.lock};
  assign req = rd | wr;

  assign lock_break   = lock_valid && (req == 2'b11) && (lock_cnt == CNT_W'(LOCK_MAX));
  assign locked_grant = gnt_valid && lock_valid && (gnt_id == lock_owner) && (req == 2'b11);

  rr_arb2 u_arb (
    .req        (req),
    .last_grant (last_grant),
    .lock_valid (lock_valid),
    .lock_owner (lock_owner),
    .lock_break (lock_break),
    .gnt_valid  (gnt_valid),
    .gnt_id     (gnt_id)
  );

  always_comb begin
    mem_chipselect = gnt_valid;
    mem_write      = gnt_valid & wr[gnt_id];
    mem_address    = (gnt_id == M1) ? m1.address   : m0.address;
    mem_writedata  = (gnt_id == M1) ? m1.writedata : m0.writedata;
    mem_byteenable = '0;
    if (gnt_valid)
      mem_byteenable = (gnt_id == M1) ? m1.byteenable : m0.byteenable;
  end

  assign mem_clken = reset_n;

  assign m0.waitrequest   = ~(gnt_valid && (gnt_id == M0));
  assign m1.waitrequest   = ~(gnt_valid && (gnt_id == M1));
  assign m0.readdata      = mem_readdata;
  assign m1.readdata      = mem_readdata;
  assign m0.readdatavalid = reset_n & rsp_valid & (rsp_id == M0);
  assign m1.readdatavalid = reset_n & rsp_valid & (rsp_id == M1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant <= M1;
      lock_valid <= 1'b0;
      lock_owner <= M0;
      lock_cnt   <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= M0;
    end else begin
      rsp_valid <= gnt_valid & rd[gnt_id] & ~wr[gnt_id];
      if (gnt_valid) begin
        rsp_id     <= gnt_id;
        last_grant <= gnt_id;
        if (lock_break) begin
          lock_valid <= 1'b0;
        end else if (lk[gnt_id]) begin
          lock_valid <= 1'b1;
          lock_owner <= gnt_id;
        end else begin
          lock_valid <= 1'b0;
        end
      end
      if (locked_grant && lk[gnt_id])
        lock_cnt <= lock_cnt + 1'b1;
      else
        lock_cnt <= '0;
    end
  end

  a_m0_rd_wr: assert property (@(posedge clk) disable iff (!reset_n) !(m0.read && m0.write));
  a_m1_rd_wr: assert property (@(posedge clk) disable iff (!reset_n) !(m1.read && m1.write));

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Bench for onchip_mem_arbiter: directed scenarios plus randomized traffic
// compared against a rule-level arbitration model and a reference memory image.
module tb_onchip_mem_arbiter;
  import onchip_mem_pkg::*;

  localparam int ADDR_W   = DEF_ADDR_W;
  localparam int DATA_W   = DEF_DATA_W;
  localparam int BE_W     = DEF_BE_W;
  localparam int LOCK_MAX = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;

  onchip_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W)) m0 ();
  onchip_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W)) m1 ();

  logic [ADDR_W-1:0] mem_address;
  logic [BE_W-1:0]   mem_byteenable;
  logic              mem_chipselect, mem_write, mem_clken;
  logic [DATA_W-1:0] mem_writedata;
  logic [DATA_W-1:0] mem_readdata;

  onchip_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W), .LOCK_MAX(LOCK_MAX)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .m0             (m0),
    .m1             (m1),
    .mem_address    (mem_address),
    .mem_byteenable (mem_byteenable),
    .mem_chipselect (mem_chipselect),
    .mem_write      (mem_write),
    .mem_writedata  (mem_writedata),
    .mem_clken      (mem_clken),
    .mem_readdata   (mem_readdata)
  );

  function automatic logic [31:0] init_val(int i);
    return (i == 1023) ? 32'h1122_3344 : (32'hA5A5_0000 | 32'(i));
  endfunction

  function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] nw, logic [3:0] be);
    for (int b = 0; b < 4; b++)
      if (be[b]) old[8*b +: 8] = nw[8*b +: 8];
    return old;
  endfunction

  // RAM environment: one-cycle read latency, byte-enabled writes.
  logic [DATA_W-1:0] ram [0:1023];
  logic preloaded = 1'b0;
  always @(posedge clk) begin
    if (!preloaded) begin
      for (int i = 0; i < 1024; i++) ram[i] <= init_val(i);
      preloaded <= 1'b1;
    end else if (mem_clken && mem_chipselect) begin
      if (mem_write) ram[mem_address] <= merge(ram[mem_address], mem_writedata, mem_byteenable);
      else           mem_readdata <= ram[mem_address];
    end
  end

  // Arbitration model: who won last, who holds a lock, how long the holder has kept the other waiting.
  int mdl_prev, mdl_holder, mdl_streak;
  logic [DATA_W-1:0] ref_mem [0:1023];

  function automatic int predict(bit r0, bit r1);
    if (!r0 && !r1) return -1;
    if (r0 != r1) return r0 ? 0 : 1;
    if (mdl_holder >= 0) return (mdl_streak >= LOCK_MAX) ? 1 - mdl_holder : mdl_holder;
    return 1 - mdl_prev;
  endfunction

  task automatic drive_idle();
    m0.read = 1'b0; m0.write = 1'b0; m0.lock = 1'b0;
    m0.address = '0; m0.byteenable = '0; m0.writedata = '0;
    m1.read = 1'b0; m1.write = 1'b0; m1.lock = 1'b0;
    m1.address = '0; m1.byteenable = '0; m1.writedata = '0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    drive_idle();
    m0.read = 1'b1; m0.address = 10'd5;
    m1.write = 1'b1; m1.address = 10'd6; m1.byteenable = 4'hF; m1.writedata = 32'h1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++; if (m0.waitrequest !== 1'b1) $display("FAIL reset_m0_waitrequest got %b want 1", m0.waitrequest); else n_pass++;
    n_checks++; if (m1.waitrequest !== 1'b1) $display("FAIL reset_m1_waitrequest got %b want 1", m1.waitrequest); else n_pass++;
    n_checks++; if (m0.readdatavalid !== 1'b0) $display("FAIL reset_m0_rdv got %b want 0", m0.readdatavalid); else n_pass++;
    n_checks++; if (m1.readdatavalid !== 1'b0) $display("FAIL reset_m1_rdv got %b want 0", m1.readdatavalid); else n_pass++;
    n_checks++; if (mem_chipselect !== 1'b0) $display("FAIL reset_chipselect got %b want 0", mem_chipselect); else n_pass++;
    n_checks++; if (mem_write !== 1'b0) $display("FAIL reset_mem_write got %b want 0", mem_write); else n_pass++;
    n_checks++; if (mem_clken !== 1'b0) $display("FAIL reset_clken got %b want 0", mem_clken); else n_pass++;
    @(posedge clk); #1;
    drive_idle();
    reset_n = 1'b1;
    @(negedge clk);
    n_checks++; if (mem_clken !== 1'b1) $display("FAIL run_clken got %b want 1", mem_clken); else n_pass++;
    n_checks++; if (mem_byteenable !== 4'h0) $display("FAIL idle_byteenable got %h want 0", mem_byteenable); else n_pass++;
  endtask

  task automatic test_first_read();
    @(posedge clk); #1;
    m0.read = 1'b1; m0.address = 10'd5;
    @(negedge clk);
    n_checks++; if (m0.waitrequest !== 1'b0) $display("FAIL first_read_m0_wait got %b want 0", m0.waitrequest); else n_pass++;
    n_checks++; if (m1.waitrequest !== 1'b1) $display("FAIL first_read_m1_wait got %b want 1", m1.waitrequest); else n_pass++;
    n_checks++; if (mem_chipselect !== 1'b1) $display("FAIL first_read_cs got %b want 1", mem_chipselect); else n_pass++;
    n_checks++; if (mem_address !== 10'd5) $display("FAIL first_read_addr got %0d want 5", mem_address); else n_pass++;
    @(posedge clk); #1;
    drive_idle();
    @(negedge clk);
    n_checks++; if (m0.readdatavalid !== 1'b1) $display("FAIL first_read_rdv got %b want 1", m0.readdatavalid); else n_pass++;
    n_checks++; if (m0.readdata !== 32'hA5A5_0005) $display("FAIL first_read_data got %h want a5a50005", m0.readdata); else n_pass++;
    n_checks++; if (m1.readdatavalid !== 1'b0) $display("FAIL first_read_m1_rdv got %b want 0", m1.readdatavalid); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int exp_w = 1;
    bit prev_m1 = 1'b0;
    @(posedge clk); #1;
    m0.write = 1'b1; m0.address = 10'd100; m0.byteenable = 4'hF;
    m1.read = 1'b1; m1.address = 10'd200;
    for (int k = 0; k < 8; k++) begin
      m0.writedata = 32'hCAFE_0000 + 32'(k);
      @(negedge clk);
      n_checks++; if (m0.waitrequest !== (exp_w != 0)) $display("FAIL alt_m0_wait cycle %0d got %b want %b", k, m0.waitrequest, exp_w != 0); else n_pass++;
      n_checks++; if (m1.waitrequest !== (exp_w != 1)) $display("FAIL alt_m1_wait cycle %0d got %b want %b", k, m1.waitrequest, exp_w != 1); else n_pass++;
      n_checks++; if (m1.readdatavalid !== prev_m1) $display("FAIL alt_m1_rdv cycle %0d got %b want %b", k, m1.readdatavalid, prev_m1); else n_pass++;
      if (prev_m1) begin
        n_checks++; if (m1.readdata !== 32'hA5A5_00C8) $display("FAIL alt_m1_data cycle %0d got %h want a5a500c8", k, m1.readdata); else n_pass++;
      end
      prev_m1 = (exp_w == 1);
      exp_w = 1 - exp_w;
      @(posedge clk); #1;
    end
    drive_idle();
    @(negedge clk);
  endtask

  task automatic test_byteenable();
    @(posedge clk); #1;
    drive_idle();
    m0.write = 1'b1; m0.address = 10'h3FF; m0.byteenable = 4'h3; m0.writedata = 32'hDEAD_BEEF;
    @(negedge clk);
    n_checks++; if (m0.waitrequest !== 1'b0) $display("FAIL be_m0_wait got %b want 0", m0.waitrequest); else n_pass++;
    n_checks++; if (mem_write !== 1'b1) $display("FAIL be_mem_write got %b want 1", mem_write); else n_pass++;
    n_checks++; if (mem_byteenable !== 4'h3) $display("FAIL be_mem_be got %h want 3", mem_byteenable); else n_pass++;
    @(posedge clk); #1;
    drive_idle();
    m1.read = 1'b1; m1.address = 10'h3FF;
    @(negedge clk);
    n_checks++; if (m1.waitrequest !== 1'b0) $display("FAIL be_m1_wait got %b want 0", m1.waitrequest); else n_pass++;
    @(posedge clk); #1;
    drive_idle();
    @(negedge clk);
    n_checks++; if (m1.readdatavalid !== 1'b1) $display("FAIL be_m1_rdv got %b want 1", m1.readdatavalid); else n_pass++;
    n_checks++; if (m1.readdata !== 32'h1122_BEEF) $display("FAIL be_m1_data got %h want 1122beef", m1.readdata); else n_pass++;
  endtask

  task automatic test_lock();
    bit exp_m1;
    @(posedge clk); #1;
    drive_idle();
    m1.read = 1'b1; m1.address = 10'd7; m1.lock = 1'b1;
    @(negedge clk);
    n_checks++; if (m1.waitrequest !== 1'b0) $display("FAIL lock_take_wait got %b want 0", m1.waitrequest); else n_pass++;
    @(posedge clk); #1;
    m0.read = 1'b1; m0.address = 10'd8;
    for (int c = 1; c <= 6; c++) begin
      exp_m1 = (c != LOCK_MAX + 1);
      @(negedge clk);
      n_checks++; if (m1.waitrequest !== !exp_m1) $display("FAIL lock_m1_wait cycle %0d got %b want %b", c, m1.waitrequest, !exp_m1); else n_pass++;
      n_checks++; if (m0.waitrequest !== exp_m1) $display("FAIL lock_m0_wait cycle %0d got %b want %b", c, m0.waitrequest, exp_m1); else n_pass++;
      @(posedge clk); #1;
    end
    drive_idle();
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    drive_idle();
    m0.read = 1'b1; m0.address = 10'd9;
    @(negedge clk);
    n_checks++; if (m0.waitrequest !== 1'b0) $display("FAIL rmid_grant got %b want 0", m0.waitrequest); else n_pass++;
    #1 reset_n = 1'b0;
    #1;
    n_checks++; if (m0.waitrequest !== 1'b1) $display("FAIL rmid_wait_in_reset got %b want 1", m0.waitrequest); else n_pass++;
    @(posedge clk); #1;
    drive_idle();
    reset_n = 1'b1;
    @(negedge clk);
    n_checks++; if (m0.readdatavalid !== 1'b0) $display("FAIL rmid_m0_rdv got %b want 0", m0.readdatavalid); else n_pass++;
    n_checks++; if (m1.readdatavalid !== 1'b0) $display("FAIL rmid_m1_rdv got %b want 0", m1.readdatavalid); else n_pass++;
    @(posedge clk); #1;
    m0.read = 1'b1; m0.address = 10'd1;
    m1.read = 1'b1; m1.address = 10'd2;
    @(negedge clk);
    n_checks++; if (m0.waitrequest !== 1'b0) $display("FAIL rmid_tie_m0 got %b want 0", m0.waitrequest); else n_pass++;
    n_checks++; if (m1.waitrequest !== 1'b1) $display("FAIL rmid_tie_m1 got %b want 1", m1.waitrequest); else n_pass++;
    @(posedge clk); #1;
    drive_idle();
    @(negedge clk);
    n_checks++; if (m0.readdatavalid !== 1'b1) $display("FAIL rmid_after_rdv got %b want 1", m0.readdatavalid); else n_pass++;
    n_checks++; if (m0.readdata !== 32'hA5A5_0001) $display("FAIL rmid_after_data got %h want a5a50001", m0.readdata); else n_pass++;
  endtask

  task automatic test_random();
    bit r [2];
    bit wv [2];
    bit l [2];
    logic [ADDR_W-1:0] a [2];
    logic [DATA_W-1:0] d [2];
    logic [BE_W-1:0] be [2];
    bit pend_valid;
    int pend_id;
    logic [DATA_W-1:0] pend_data;
    int w, op;
    bit both, held, broke;
    @(posedge clk); #1;
    drive_idle();
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    for (int i = 0; i < 1024; i++) ref_mem[i] = ram[i];
    mdl_prev = 1; mdl_holder = -1; mdl_streak = 0;
    pend_valid = 1'b0; pend_id = 0; pend_data = '0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int m = 0; m < 2; m++) begin
        op = int'($urandom_range(0, 99));
        r[m]  = (op >= 15 && op < 55);
        wv[m] = (op >= 55);
        l[m]  = ($urandom_range(0, 99) < 80);
        a[m]  = ADDR_W'($urandom_range(0, 15));
        d[m]  = $urandom();
        be[m] = BE_W'($urandom_range(1, 15));
      end
      m0.read = r[0]; m0.write = wv[0]; m0.lock = l[0]; m0.address = a[0]; m0.writedata = d[0]; m0.byteenable = be[0];
      m1.read = r[1]; m1.write = wv[1]; m1.lock = l[1]; m1.address = a[1]; m1.writedata = d[1]; m1.byteenable = be[1];
      both = (r[0] | wv[0]) && (r[1] | wv[1]);
      w = predict(r[0] | wv[0], r[1] | wv[1]);
      @(negedge clk);
      n_checks++; if (m0.waitrequest !== (w != 0)) $display("FAIL rnd_m0_wait cycle %0d got %b want %b", cyc, m0.waitrequest, w != 0); else n_pass++;
      n_checks++; if (m1.waitrequest !== (w != 1)) $display("FAIL rnd_m1_wait cycle %0d got %b want %b", cyc, m1.waitrequest, w != 1); else n_pass++;
      n_checks++; if (mem_chipselect !== (w >= 0)) $display("FAIL rnd_cs cycle %0d got %b want %b", cyc, mem_chipselect, w >= 0); else n_pass++;
      if (w >= 0) begin
        n_checks++; if (mem_write !== wv[w]) $display("FAIL rnd_mem_write cycle %0d got %b want %b", cyc, mem_write, wv[w]); else n_pass++;
        n_checks++; if (mem_address !== a[w]) $display("FAIL rnd_mem_addr cycle %0d got %h want %h", cyc, mem_address, a[w]); else n_pass++;
      end
      n_checks++; if (m0.readdatavalid !== (pend_valid && pend_id == 0)) $display("FAIL rnd_m0_rdv cycle %0d got %b want %b", cyc, m0.readdatavalid, pend_valid && pend_id == 0); else n_pass++;
      n_checks++; if (m1.readdatavalid !== (pend_valid && pend_id == 1)) $display("FAIL rnd_m1_rdv cycle %0d got %b want %b", cyc, m1.readdatavalid, pend_valid && pend_id == 1); else n_pass++;
      if (pend_valid) begin
        n_checks++;
        if (((pend_id == 0) ? m0.readdata : m1.readdata) !== pend_data)
          $display("FAIL rnd_rdata cycle %0d got %h want %h", cyc, (pend_id == 0) ? m0.readdata : m1.readdata, pend_data);
        else n_pass++;
      end
      pend_valid = (w >= 0) && r[w];
      if (pend_valid) begin
        pend_id = w;
        pend_data = ref_mem[a[w]];
      end
      if (w >= 0) begin
        if (wv[w]) ref_mem[a[w]] = merge(ref_mem[a[w]], d[w], be[w]);
        broke = both && (mdl_holder >= 0) && (w != mdl_holder);
        held  = both && (mdl_holder == w);
        mdl_prev = w;
        mdl_holder = broke ? -1 : (l[w] ? w : -1);
        mdl_streak = (held && l[w]) ? mdl_streak + 1 : 0;
      end else begin
        mdl_streak = 0;
      end
      @(posedge clk); #1;
    end
    drive_idle();
  endtask

  initial begin
    drive_idle();
    test_reset();
    test_first_read();
    test_back_to_back();
    test_byteenable();
    test_lock();
    test_reset_mid();
    test_random();
    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
